mac_accel: RTL

Memory-mapped multiply-accumulate peripheral that occupies the 16-byte window at 0x200–0x20F. The address decoder asserts its select for this window, and this block's read data returns to the decoder as the accumulator read source. It holds two operand registers and a 32-bit accumulator. On command, it runs a sequential 32-cycle shift-add multiply and adds the truncated product into the accumulator, reporting busy, done and overflow through a status register.

---
 rtl/mac_accel.sv | 107 ++++++++++
 1 files changed

// File: rtl/mac_accel.sv
// Memory-mapped multiply-accumulate peripheral (window 0x200-0x20F).
// A 32-cycle shift-add multiply adds the truncated product into a 32-bit accumulator.
module mac_accel (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_ACCUM = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [31:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_partial;
  logic [4:0]  r_cnt;
  logic        r_done;
  logic        r_ovf;

  logic [1:0]  w_sel;
  logic        w_wr;
  logic        w_busy;
  logic [32:0] w_sum;
  logic        w_unused;

  assign w_sel    = i_addr[3:2];
  assign w_wr     = i_enable && (i_we == 4'b1111);
  assign w_busy   = (r_state != ST_IDLE);
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_partial};
  assign w_unused = ^{i_addr[31:4], i_addr[1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_opa     <= 32'd0;
      r_opb     <= 32'd0;
      r_acc     <= 32'd0;
      r_mcand   <= 64'd0;
      r_mplier  <= 32'd0;
      r_partial <= 32'd0;
      r_cnt     <= 5'd0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      // Operand writes are always accepted; the running multiply uses its own copies.
      if (w_wr && w_sel == 2'd0) r_opa <= i_wdata;
      if (w_wr && w_sel == 2'd1) r_opb <= i_wdata;

      case (r_state)
        ST_IDLE: begin
          if (w_wr && w_sel == 2'd3) r_acc <= i_wdata;
          if (w_wr && w_sel == 2'd2) begin
            if (i_wdata[1]) begin
              r_acc <= 32'd0;
              r_ovf <= 1'b0;
            end
            if (i_wdata[0]) begin
              r_mcand   <= {32'd0, r_opa};
              r_mplier  <= r_opb;
              r_partial <= 32'd0;
              r_cnt     <= 5'd0;
              r_done    <= 1'b0;
              r_state   <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (r_mplier[0]) r_partial <= r_partial + r_mcand[31:0];
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          r_acc   <= w_sum[31:0];
          r_ovf   <= r_ovf | w_sum[32];
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    if (i_enable) begin
      case (w_sel)
        2'd0:    o_rdata = r_opa;
        2'd1:    o_rdata = r_opb;
        2'd2:    o_rdata = {29'd0, r_ovf, r_done, w_busy};
        default: o_rdata = r_acc;
      endcase
    end
  end

endmodule
